lvds_rx_frame_aligner: RTL and testbench
========================================

Name: lvds_rx_frame_aligner

Overview:
Consumes the single-ended serial lanes produced by the LVDS input buffer stage: BUS_WIDTH data lanes plus one frame lane, all SDR-sampled on the buffered source clock. It deserialises each lane MSB-first into WORD_WIDTH-bit words. It finds word alignment by hunting for FRAME_PATTERN on the frame lane. It confirms lock over LOCK_COUNT frames, then emits aligned parallel words with a valid strobe and monitors the frame lane for loss of lock.

Parameters:
BUS_WIDTH, 1, number of serial data lanes
WORD_WIDTH, 8, bits per deserialised word (>=4)
FRAME_PATTERN, 8'hF0, expected frame-lane word; WORD_WIDTH bits; must be non-periodic (no rotation other than 0 equals itself)
LOCK_COUNT, 4, consecutive boundary matches required to declare lock (>=1)
LOSS_COUNT, 2, consecutive boundary mismatches that drop lock (>=1)

Ports:
clock  input  1  buffered LVDS source clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
data_s  input  BUS_WIDTH  serial data lanes from buffer stage
frame_s  input  1  serial frame lane from buffer stage
align_enable  input  1  1 = run alignment/lock; 0 = hold in SEARCH
data_out  output  BUS_WIDTH*WORD_WIDTH  aligned words; lane i at [i*WORD_WIDTH +: WORD_WIDTH]; first-received bit is MSB
word_valid  output  1  one-cycle strobe, data_out valid
locked  output  1  high in LOCKED state
bit_offset  output  $clog2(WORD_WIDTH)  free-running counter phase chosen as word boundary
lock_lost  output  1  one-cycle pulse on LOCKED->SEARCH due to frame mismatches

Behaviour:
- Reset (async assert, sync-safe deassert internally not required): all shift registers, data_out, word_valid, locked, bit_offset, lock_lost, counters = 0; state = SEARCH.
- Every edge: each lane shift register sr <= {sr[WORD_WIDTH-2:0], in}; frame register fr likewise; free counter fcnt increments modulo WORD_WIDTH (WORD_WIDTH-1 -> 0).
- match = (fr == FRAME_PATTERN), evaluated on registered fr. boundary = (fcnt == bit_offset).
- States: SEARCH, CONFIRM, LOCKED.
- SEARCH: if align_enable && match: bit_offset <= fcnt, good_cnt <= 1; if LOCK_COUNT==1 go LOCKED, else CONFIRM. Match tested every cycle.
- CONFIRM: act only when boundary. match -> good_cnt++; reaching LOCK_COUNT -> LOCKED. Mismatch -> SEARCH, good_cnt <= 0.
- LOCKED: locked = 1. On each boundary: data_out <= all lane sr, word_valid <= 1 next cycle (exactly one cycle per WORD_WIDTH cycles). Mismatch at boundary -> miss_cnt++; match -> miss_cnt <= 0. miss_cnt reaching LOSS_COUNT -> SEARCH, lock_lost pulses 1 cycle, locked falls same edge. Word on the boundary that triggers loss is not emitted.
- Latency: last bit of a word sampled at edge E -> sr complete after E -> data_out/word_valid high after E+1.
- align_enable = 0 in any state: next edge state = SEARCH, locked = 0, word_valid = 0, counters cleared, no lock_lost pulse; data_out holds last value.
- Simultaneous loss and align_enable drop: align_enable wins, no lock_lost.
- bit_offset holds through SEARCH until a new match; data_out holds between strobes.
- Reset mid-LOCKED: all outputs 0 immediately (asynchronous), relock from SEARCH after release.

Test Plan:
- Reset: hold reset_n=0 with toggling inputs -> all outputs 0; release -> locked=0, word_valid=0 until a pattern arrives.
- Clean lock: WORD_WIDTH=8, frame lane repeating 0xF0, start skewed by 3 bits, data lane repeating 0xA5 aligned to frame -> locked rises after 4th matching boundary; thereafter word_valid every 8 cycles with data_out=0xA5, bit_offset constant.
- Confirm abort: one frame word corrupted to 0xF1 during CONFIRM -> back to SEARCH, locked never asserts until 4 clean frames.
- Single miss tolerance: LOSS_COUNT=2, one corrupted frame word while LOCKED -> locked stays 1, no lock_lost, strobes continue.
- Loss of lock: two consecutive corrupted frame words -> lock_lost one-cycle pulse, locked=0, no word_valid on that boundary; relock after 4 clean frames.
- Enable/reset mid-lock: drop align_enable while LOCKED -> locked=0 next edge, no lock_lost. Re-enable -> relock. Assert reset_n=0 mid-word -> outputs 0 asynchronously.

Source files
------------

// File: rtl/lvds_rx_frame_aligner_if.sv
// Lane/status bundle between the LVDS buffer stage (master) and the frame aligner (slave).
interface lvds_rx_frame_aligner_if #(
    parameter int unsigned BUS_WIDTH  = 1,
    parameter int unsigned WORD_WIDTH = 8
);
    logic [BUS_WIDTH-1:0]            data_s;
    logic                            frame_s;
    logic                            align_enable;
    logic [BUS_WIDTH*WORD_WIDTH-1:0] data_out;
    logic                            word_valid;
    logic                            locked;
    logic [$clog2(WORD_WIDTH)-1:0]   bit_offset;
    logic                            lock_lost;

    modport master (
        output data_s, frame_s, align_enable,
        input  data_out, word_valid, locked, bit_offset, lock_lost
    );

    modport slave (
        input  data_s, frame_s, align_enable,
        output data_out, word_valid, locked, bit_offset, lock_lost
    );
endinterface

// File: rtl/lvds_rx_frame_aligner.sv
// Deserialises LVDS lanes MSB-first, hunts FRAME_PATTERN on the frame lane for the
// word boundary, confirms lock over LOCK_COUNT frames and drops it after LOSS_COUNT misses.
module lvds_rx_frame_aligner #(
    parameter int unsigned           BUS_WIDTH     = 1,
    parameter int unsigned           WORD_WIDTH    = 8,
    parameter logic [WORD_WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int unsigned           LOCK_COUNT    = 4,
    parameter int unsigned           LOSS_COUNT    = 2
) (
    input logic                    clock,
    input logic                    reset_n,
    lvds_rx_frame_aligner_if.slave bus
);
    localparam int unsigned   OW       = $clog2(WORD_WIDTH);
    localparam int unsigned   GW       = $clog2(LOCK_COUNT + 1);
    localparam int unsigned   MW       = $clog2(LOSS_COUNT + 1);
    localparam logic [OW-1:0] FCNT_MAX = OW'(WORD_WIDTH - 1);
    localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] LOSS_N   = MW'(LOSS_COUNT);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    state_t                               state;
    logic [BUS_WIDTH-1:0][WORD_WIDTH-1:0] sr;
    logic [BUS_WIDTH-1:0][WORD_WIDTH-1:0] data_out_q;
    logic [WORD_WIDTH-1:0]                fr;
    logic [OW-1:0]                        fcnt;
    logic [OW-1:0]                        offset_q;
    logic [GW-1:0]                        good_cnt;
    logic [MW-1:0]                        miss_cnt;
    logic                                 word_valid_q;
    logic                                 locked_q;
    logic                                 lock_lost_q;

    logic          match;
    logic          boundary;
    logic [GW-1:0] good_inc;
    logic [MW-1:0] miss_inc;

    assign match    = (fr == FRAME_PATTERN);
    assign boundary = (fcnt == offset_q);
    assign good_inc = good_cnt + GW'(1);
    assign miss_inc = miss_cnt + MW'(1);

    assign bus.data_out   = data_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.locked     = locked_q;
    assign bus.bit_offset = offset_q;
    assign bus.lock_lost  = lock_lost_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr   <= '0;
            fr   <= '0;
            fcnt <= '0;
        end else begin
            fr <= {fr[WORD_WIDTH-2:0], bus.frame_s};
            for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
                sr[i] <= {sr[i][WORD_WIDTH-2:0], bus.data_s[i]};
            end
            fcnt <= (fcnt == FCNT_MAX) ? '0 : fcnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= SEARCH;
            offset_q     <= '0;
            good_cnt     <= '0;
            miss_cnt     <= '0;
            data_out_q   <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            // Disable overrides everything, including a loss on the same edge.
            if (!bus.align_enable) begin
                state    <= SEARCH;
                locked_q <= 1'b0;
                good_cnt <= '0;
                miss_cnt <= '0;
            end else begin
                unique case (state)
                    SEARCH: begin
                        if (match) begin
                            offset_q <= fcnt;
                            good_cnt <= GW'(1);
                            miss_cnt <= '0;
                            if (LOCK_COUNT == 1) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (boundary) begin
                            if (match) begin
                                good_cnt <= good_inc;
                                if (good_inc == LOCK_N) begin
                                    state    <= LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                state    <= SEARCH;
                                good_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (boundary) begin
                            // The word on the boundary that loses lock is dropped.
                            if (match || miss_inc != LOSS_N) begin
                                data_out_q   <= sr;
                                word_valid_q <= 1'b1;
                            end
                            if (match) begin
                                miss_cnt <= '0;
                            end else if (miss_inc == LOSS_N) begin
                                state       <= SEARCH;
                                locked_q    <= 1'b0;
                                lock_lost_q <= 1'b1;
                                miss_cnt    <= '0;
                                good_cnt    <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lvds_rx_frame_aligner.sv
// Randomised bench for lvds_rx_frame_aligner: bit-history reference model checked every
// cycle, plus literal pins on lock timing, offset, data and reset behaviour.
module tb_lvds_rx_frame_aligner;
    localparam int unsigned   BW  = 2;
    localparam int unsigned   WW  = 8;
    localparam int unsigned   OW  = $clog2(WW);
    localparam logic [WW-1:0] PAT = 8'hF0;
    localparam int unsigned   LC  = 4;
    localparam int unsigned   LS  = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lvds_rx_frame_aligner_if #(.BUS_WIDTH(BW), .WORD_WIDTH(WW)) bus ();

    lvds_rx_frame_aligner #(
        .BUS_WIDTH(BW), .WORD_WIDTH(WW), .FRAME_PATTERN(PAT),
        .LOCK_COUNT(LC), .LOSS_COUNT(LS)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, got, want);
    endfunction

    // Reference model: keeps the last WW sampled bits per lane and applies the lock rules.
    logic          m_fh[$];
    logic [BW-1:0] m_dh[$];
    int unsigned   m_cyc   = 0;
    int unsigned   m_mode  = 0;  // 0 search, 1 confirm, 2 locked
    int unsigned   m_good  = 0;
    int unsigned   m_miss  = 0;
    logic [OW-1:0] m_off   = '0;
    logic [BW*WW-1:0] m_out = '0;
    logic m_valid  = 1'b0;
    logic m_locked = 1'b0;
    logic m_lost   = 1'b0;
    logic m_match, m_bnd, m_emit;

    function automatic logic [WW-1:0] win_f();
        logic [WW-1:0] w = '0;
        int n = m_fh.size();
        for (int k = 0; k < int'(WW); k++) begin
            int idx = n - int'(WW) + k;
            w = {w[WW-2:0], (idx >= 0) ? m_fh[idx] : 1'b0};
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] win_d(input int unsigned lane);
        logic [WW-1:0] w = '0;
        int n = m_dh.size();
        for (int k = 0; k < int'(WW); k++) begin
            int idx = n - int'(WW) + k;
            w = {w[WW-2:0], (idx >= 0) ? m_dh[idx][lane] : 1'b0};
        end
        return w;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_fh.delete();
            m_dh.delete();
            m_cyc = 0; m_mode = 0; m_good = 0; m_miss = 0; m_off = '0;
            m_out = '0; m_valid = 1'b0; m_locked = 1'b0; m_lost = 1'b0;
        end else begin
            m_match = (win_f() == PAT);
            m_bnd   = ((m_cyc % WW) == 32'(m_off));
            m_valid = 1'b0; m_lost = 1'b0; m_emit = 1'b0;
            if (!bus.align_enable) begin
                m_mode = 0; m_good = 0; m_miss = 0;
            end else if (m_mode == 0) begin
                if (m_match) begin
                    m_off  = OW'(m_cyc % WW);
                    m_good = 1; m_miss = 0;
                    m_mode = (m_good >= LC) ? 2 : 1;
                end
            end else if (m_bnd) begin
                if (m_mode == 1) begin
                    if (m_match) begin
                        m_good++;
                        if (m_good >= LC) m_mode = 2;
                    end else begin
                        m_mode = 0; m_good = 0;
                    end
                end else begin
                    if (m_match) begin
                        m_miss = 0; m_emit = 1'b1;
                    end else begin
                        m_miss++;
                        if (m_miss >= LS) begin
                            m_mode = 0; m_lost = 1'b1; m_miss = 0; m_good = 0;
                        end else m_emit = 1'b1;
                    end
                end
            end
            if (m_emit) begin
                for (int unsigned l = 0; l < BW; l++) m_out[l*WW +: WW] = win_d(l);
                m_valid = 1'b1;
            end
            m_locked = (m_mode == 2);
            m_fh.push_back(bus.frame_s);
            m_dh.push_back(bus.data_s);
            if (m_fh.size() > WW) m_fh.pop_front();
            if (m_dh.size() > WW) m_dh.pop_front();
            m_cyc++;
        end
    end

    always @(negedge clock) begin
        chk("locked",     64'(bus.locked),     64'(m_locked));
        chk("word_valid", 64'(bus.word_valid), 64'(m_valid));
        chk("lock_lost",  64'(bus.lock_lost),  64'(m_lost));
        chk("bit_offset", 64'(bus.bit_offset), 64'(m_off));
        chk("data_out",   64'(bus.data_out),   64'(m_out));
    end

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic f, input logic [BW-1:0] d);
        bus.frame_s = f;
        bus.data_s  = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic send_bits(input logic [WW-1:0] fw, input logic [WW-1:0] d0,
                             input int unsigned first, input int unsigned last);
        for (int unsigned b = first; b <= last; b++)
            step(fw[WW-1-b], {1'($urandom), d0[WW-1-b]});
    endtask

    task automatic send_word(input logic [WW-1:0] fw);
        send_bits(fw, 8'hA5, 0, WW - 1);
    endtask

    task automatic pin_dut_zero(input string tag);
        chk({tag, "_locked"},     64'(bus.locked),     64'd0);
        chk({tag, "_word_valid"}, 64'(bus.word_valid), 64'd0);
        chk({tag, "_lock_lost"},  64'(bus.lock_lost),  64'd0);
        chk({tag, "_bit_offset"}, 64'(bus.bit_offset), 64'd0);
        chk({tag, "_data_out"},   64'(bus.data_out),   64'd0);
    endtask

    logic [WW-1:0] pw, dw;

    initial begin
        bus.frame_s = 1'b0;
        bus.data_s  = '0;
        bus.align_enable = 1'b1;
        pw = PAT;
        dw = 8'hA5;
        @(negedge clock);

        // Reset held while inputs toggle.
        for (int i = 0; i < 6; i++) step(1'($urandom), BW'($urandom));
        pin_dut_zero("rst_hold");
        reset_n = 1'b1;

        // Clean lock: 3 skew bits, then repeating PAT with lane0 = A5.
        for (int i = 0; i < 3 + 8 * int'(WW); i++) begin
            if (i < 3) step(1'b0, {1'($urandom), 1'b0});
            else step(pw[WW-1-((i-3)%WW)], {1'($urandom), dw[WW-1-((i-3)%WW)]});
            if (i == 34) begin
                chk("pin_prelock_dut", 64'(bus.locked), 64'd0);
                chk("pin_prelock_model", 64'(m_locked), 64'd0);
            end
            if (i == 35) begin
                chk("pin_lock_dut", 64'(bus.locked), 64'd1);
                chk("pin_lock_model", 64'(m_locked), 64'd1);
                chk("pin_offset_dut", 64'(bus.bit_offset), 64'd3);
                chk("pin_offset_model", 64'(m_off), 64'd3);
            end
            if (i == 42) chk("pin_novalid_42", 64'(bus.word_valid), 64'd0);
            if (i == 43 || i == 51) begin
                chk("pin_valid_dut", 64'(bus.word_valid), 64'd1);
                chk("pin_lane0_dut", 64'(bus.data_out[WW-1:0]), 64'hA5);
                chk("pin_lane0_model", 64'(m_out[WW-1:0]), 64'hA5);
            end
            if (i == 44) chk("pin_novalid_44", 64'(bus.word_valid), 64'd0);
        end

        // Single miss while locked is tolerated.
        send_word(8'hF1);
        repeat (3) send_word(PAT);
        chk("pin_single_miss_locked", 64'(bus.locked), 64'd1);

        // Two consecutive misses drop lock; the losing boundary emits no word.
        send_word(8'hF1);
        send_word(8'hF1);
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_loss_pulse", 64'(bus.lock_lost), 64'd1);
        chk("pin_loss_unlocked", 64'(bus.locked), 64'd0);
        chk("pin_loss_novalid", 64'(bus.word_valid), 64'd0);
        send_bits(PAT, 8'hA5, 1, WW - 1);
        repeat (3) send_word(PAT);
        chk("pin_relock_pending", 64'(bus.locked), 64'd0);
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_relocked", 64'(bus.locked), 64'd1);
        send_bits(PAT, 8'hA5, 1, WW - 1);

        // Enable drop while locked: immediate unlock, no loss pulse.
        bus.align_enable = 1'b0;
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_dis_unlocked", 64'(bus.locked), 64'd0);
        chk("pin_dis_nolost", 64'(bus.lock_lost), 64'd0);
        send_bits(PAT, 8'hA5, 1, WW - 1);
        repeat (2) send_word(PAT);

        // Re-enable, then abort confirmation with a corrupted frame.
        bus.align_enable = 1'b1;
        send_word(PAT);
        send_word(PAT);
        send_word(8'hF1);
        repeat (3) send_word(PAT);
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_abort_unlocked", 64'(bus.locked), 64'd0);
        send_bits(PAT, 8'hA5, 1, WW - 1);
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_abort_relocked", 64'(bus.locked), 64'd1);
        send_bits(PAT, 8'hA5, 1, WW - 1);

        // Random corruption, bit slips and enable drops.
        for (int w = 0; w < 300; w++) begin
            bus.align_enable = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 39) == 0)
                for (int s = 0; s < int'($urandom_range(1, WW - 1)); s++)
                    step(1'($urandom), BW'($urandom));
            if ($urandom_range(0, 9) == 0) send_bits(WW'($urandom), WW'($urandom), 0, WW - 1);
            else send_bits(PAT, WW'($urandom), 0, WW - 1);
        end

        // Asynchronous reset mid-word while locked.
        bus.align_enable = 1'b1;
        repeat (10) send_word(PAT);
        chk("pin_prereset_locked", 64'(bus.locked), 64'd1);
        send_bits(PAT, 8'hA5, 0, 2);
        #2 reset_n = 1'b0;
        #1 pin_dut_zero("rst_async");
        @(negedge clock);
        repeat (3) step(1'($urandom), BW'($urandom));
        reset_n = 1'b1;
        repeat (4) send_word(PAT);
        send_bits(PAT, 8'hA5, 0, 0);
        chk("pin_post_reset_locked", 64'(bus.locked), 64'd1);
        chk("pin_post_reset_offset", 64'(bus.bit_offset), 64'd0);
        send_bits(PAT, 8'hA5, 1, WW - 1);
        repeat (2) send_word(PAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
